circle_engine: RTL and testbench

//  Parametrised midpoint-circle rasteriser that drives the VGA adapter plot port.

---
 rtl/circle_engine_if.sv | 29 ++
 rtl/circle_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_circle_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/circle_engine_if.sv
// Drawing-request / VGA plot-port bundle between the drawing controller,
// circle_engine and the vga_adapter pixel interface.
interface circle_engine_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           start;
    logic [2:0]     colour;
    logic [X_W-1:0] centre_x;
    logic [Y_W-1:0] centre_y;
    logic [X_W-1:0] radius;
    logic           fill;
    logic [7:0]     octant_mask;
    logic           done;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;

    modport master (
        output start, colour, centre_x, centre_y, radius, fill, octant_mask,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, colour, centre_x, centre_y, radius, fill, octant_mask,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser: outline (per-octant mask) or filled disc,
// clipped to the visible screen, one pixel per cycle on a registered plot port.
module circle_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic             clk,
    input  logic             rstn,
    circle_engine_if.slave   bus
);
    // Two guard bits keep cx+ox and the decision variable from wrapping.
    localparam int A_W = X_W + 2;
    typedef logic signed [A_W-1:0] arith_t;

    localparam arith_t ZERO     = '0;
    localparam arith_t ONE      = {{(A_W-1){1'b0}}, 1'b1};
    localparam arith_t SCR_W_A  = arith_t'(SCREEN_W);
    localparam arith_t SCR_H_A  = arith_t'(SCREEN_H);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OCT    = 3'd1,
        ST_SPAN   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic arith_t ext_x(input logic [X_W-1:0] v);
        return {{(A_W-X_W){1'b0}}, v};
    endfunction

    function automatic arith_t ext_y(input logic [Y_W-1:0] v);
        return {{(A_W-Y_W){1'b0}}, v};
    endfunction

    function automatic logic on_screen(input arith_t x, input arith_t y);
        return (!x[A_W-1]) && (x < SCR_W_A) && (!y[A_W-1]) && (y < SCR_H_A);
    endfunction

    // Spans 0/1 are the wide rows (half-width ox), spans 2/3 the narrow ones (oy).
    function automatic arith_t half_width(input logic [1:0] s, input arith_t ox, input arith_t oy);
        return s[1] ? oy : ox;
    endfunction

    state_t     state_r, state_s;
    arith_t     cx_r, cy_r, ox_r, oy_r, crit_r, px_r;
    arith_t     cx_s, cy_s, ox_s, oy_s, crit_s, px_s;
    arith_t     ox_n_s, oy_n_s, rad_s;
    logic [2:0] oct_r, oct_s;
    logic [1:0] span_r, span_s;
    logic       fill_r, fill_s;
    logic [7:0] mask_r, mask_s;
    logic [2:0] colour_r, colour_s;
    arith_t     pt_x_s, pt_y_s;
    logic       pt_en_s;

    logic [X_W-1:0] vga_x_r;
    logic [Y_W-1:0] vga_y_r;
    logic [2:0]     vga_colour_r;
    logic           vga_plot_r;
    logic           done_r;

    // Next-state, datapath update and current candidate pixel
    always_comb begin
        state_s  = state_r;
        cx_s     = cx_r;
        cy_s     = cy_r;
        ox_s     = ox_r;
        oy_s     = oy_r;
        crit_s   = crit_r;
        px_s     = px_r;
        oct_s    = oct_r;
        span_s   = span_r;
        fill_s   = fill_r;
        mask_s   = mask_r;
        colour_s = colour_r;
        ox_n_s   = ox_r;
        oy_n_s   = oy_r;
        rad_s    = ext_x(bus.radius);
        pt_x_s   = px_r;
        pt_y_s   = cy_r;
        pt_en_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    cx_s     = ext_x(bus.centre_x);
                    cy_s     = ext_y(bus.centre_y);
                    ox_s     = rad_s;
                    oy_s     = ZERO;
                    crit_s   = ONE - rad_s;
                    px_s     = ext_x(bus.centre_x) - rad_s;
                    oct_s    = 3'd0;
                    span_s   = 2'd0;
                    fill_s   = bus.fill;
                    mask_s   = bus.octant_mask;
                    colour_s = bus.colour;
                    state_s  = bus.fill ? ST_SPAN : ST_OCT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_OCT: begin
                case (oct_r)
                    3'd0: begin pt_x_s = cx_r + ox_r; pt_y_s = cy_r + oy_r; end
                    3'd1: begin pt_x_s = cx_r + oy_r; pt_y_s = cy_r + ox_r; end
                    3'd2: begin pt_x_s = cx_r - oy_r; pt_y_s = cy_r + ox_r; end
                    3'd3: begin pt_x_s = cx_r - ox_r; pt_y_s = cy_r + oy_r; end
                    3'd4: begin pt_x_s = cx_r - ox_r; pt_y_s = cy_r - oy_r; end
                    3'd5: begin pt_x_s = cx_r - oy_r; pt_y_s = cy_r - ox_r; end
                    3'd6: begin pt_x_s = cx_r + oy_r; pt_y_s = cy_r - ox_r; end
                    3'd7: begin pt_x_s = cx_r + ox_r; pt_y_s = cy_r - oy_r; end
                    default: begin pt_x_s = cx_r; pt_y_s = cy_r; end
                endcase
                pt_en_s = mask_r[oct_r];
                oct_s   = oct_r + 3'd1;
                if (oct_r == 3'd7) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_OCT;
                end
            end

            ST_SPAN: begin
                case (span_r)
                    2'd0:    pt_y_s = cy_r + oy_r;
                    2'd1:    pt_y_s = cy_r - oy_r;
                    2'd2:    pt_y_s = cy_r + ox_r;
                    2'd3:    pt_y_s = cy_r - ox_r;
                    default: pt_y_s = cy_r;
                endcase
                pt_x_s  = px_r;
                pt_en_s = 1'b1;
                if (px_r == cx_r + half_width(span_r, ox_r, oy_r)) begin
                    span_s = span_r + 2'd1;
                    px_s   = cx_r - half_width(span_r + 2'd1, ox_r, oy_r);
                    if (span_r == 2'd3) begin
                        state_s = ST_UPDATE;
                    end else begin
                        state_s = ST_SPAN;
                    end
                end else begin
                    px_s    = px_r + ONE;
                    state_s = ST_SPAN;
                end
            end

            ST_UPDATE: begin
                oy_n_s = oy_r + ONE;
                if (crit_r <= ZERO) begin
                    ox_n_s = ox_r;
                    crit_s = crit_r + oy_n_s + oy_n_s + ONE;
                end else begin
                    ox_n_s = ox_r - ONE;
                    crit_s = crit_r + (oy_n_s - ox_n_s) + (oy_n_s - ox_n_s) + ONE;
                end
                ox_s   = ox_n_s;
                oy_s   = oy_n_s;
                oct_s  = 3'd0;
                span_s = 2'd0;
                px_s   = cx_r - ox_n_s;
                if (oy_n_s <= ox_n_s) begin
                    state_s = fill_r ? ST_SPAN : ST_OCT;
                end else begin
                    state_s = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request and working registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            cx_r     <= ZERO;
            cy_r     <= ZERO;
            ox_r     <= ZERO;
            oy_r     <= ZERO;
            crit_r   <= ZERO;
            px_r     <= ZERO;
            oct_r    <= 3'd0;
            span_r   <= 2'd0;
            fill_r   <= 1'b0;
            mask_r   <= 8'h00;
            colour_r <= 3'd0;
        end else begin
            state_r  <= state_s;
            cx_r     <= cx_s;
            cy_r     <= cy_s;
            ox_r     <= ox_s;
            oy_r     <= oy_s;
            crit_r   <= crit_s;
            px_r     <= px_s;
            oct_r    <= oct_s;
            span_r   <= span_s;
            fill_r   <= fill_s;
            mask_r   <= mask_s;
            colour_r <= colour_s;
        end
    end

    // Registered plot port and completion flag; clipped pixels keep their cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vga_x_r      <= '0;
            vga_y_r      <= '0;
            vga_colour_r <= 3'd0;
            vga_plot_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            vga_x_r      <= pt_x_s[X_W-1:0];
            vga_y_r      <= pt_y_s[Y_W-1:0];
            vga_colour_r <= colour_r;
            vga_plot_r   <= pt_en_s && on_screen(pt_x_s, pt_y_s);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign bus.vga_x      = vga_x_r;
    assign bus.vga_y      = vga_y_r;
    assign bus.vga_colour = vga_colour_r;
    assign bus.vga_plot   = vga_plot_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_circle_engine.sv
// Bench for circle_engine: directed table, property checks, random draws
// against a loop-based midpoint reference model, reset and handshake sequences.
module tb_circle_engine;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int SW  = 160;
    localparam int SH  = 120;
    localparam int NT  = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    circle_engine_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    circle_engine #(.X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct { int x; int y; } pt_t;
    typedef struct {
        int cx; int cy; int r; bit f; logic [7:0] m; int exp_plots; int exp_cycles;
    } vec_t;

    int  n_vec = 0;
    int  n_bad = 0;
    pt_t exp_q[$];
    pt_t obs_q[$];
    int  exp_cyc;
    int  obs_cyc;
    int  bad_col;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit vis(input int x, input int y);
        return (x >= 0) && (x < SW) && (y >= 0) && (y < SH);
    endfunction

    // Reference: plain midpoint loop producing the ordered list of visible plots
    task automatic model(input int cx, input int cy, input int r, input bit f, input logic [7:0] m);
        int ox, oy, crit, slots, iters;
        int ax[8];
        int ay[8];
        int row[4];
        int hw[4];
        ox = r; oy = 0; crit = 1 - r; slots = 0; iters = 0;
        exp_q.delete();
        do begin
            if (!f) begin
                ax = '{ox, oy, -oy, -ox, -ox, -oy, oy, ox};
                ay = '{oy, ox, ox, oy, -oy, -ox, -ox, -oy};
                for (int k = 0; k < 8; k++) begin
                    slots++;
                    if (m[k] && vis(cx + ax[k], cy + ay[k]))
                        exp_q.push_back(pt_t'{cx + ax[k], cy + ay[k]});
                end
            end else begin
                row = '{cy + oy, cy - oy, cy + ox, cy - ox};
                hw  = '{ox, ox, oy, oy};
                for (int s = 0; s < 4; s++) begin
                    for (int x = cx - hw[s]; x <= cx + hw[s]; x++) begin
                        slots++;
                        if (vis(x, row[s])) exp_q.push_back(pt_t'{x, row[s]});
                    end
                end
            end
            iters++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
        // one latch cycle, one per pixel slot, one per update
        exp_cyc = 1 + slots + iters;
    endtask

    task automatic draw(input int cx, input int cy, input int r, input bit f,
                        input logic [7:0] m, input logic [2:0] col);
        obs_q.delete();
        obs_cyc = 0;
        bad_col = 0;
        bus.centre_x    = cx[X_W-1:0];
        bus.centre_y    = cy[Y_W-1:0];
        bus.radius      = r[X_W-1:0];
        bus.fill        = f;
        bus.octant_mask = m;
        bus.colour      = col;
        bus.start       = 1'b1;
        do begin
            @(negedge clk);
            obs_cyc++;
            if (obs_cyc == 1) begin
                bus.centre_x    = X_W'($urandom);
                bus.centre_y    = Y_W'($urandom);
                bus.radius      = X_W'($urandom);
                bus.fill        = ~f;
                bus.octant_mask = 8'($urandom);
                bus.colour      = ~col;
            end
            if (bus.vga_plot === 1'b1) begin
                obs_q.push_back(pt_t'{int'(bus.vga_x), int'(bus.vga_y)});
                if (bus.vga_colour !== col) bad_col++;
            end
        end while (bus.done !== 1'b1 && obs_cyc < 20000);
    endtask

    task automatic run_case(input string name, input int cx, input int cy, input int r,
                            input bit f, input logic [7:0] m, input logic [2:0] col);
        int n;
        model(cx, cy, r, f, m);
        draw(cx, cy, r, f, m, col);
        check({name, " cycles"}, obs_cyc, exp_cyc);
        check({name, " plots"}, obs_q.size(), exp_q.size());
        check({name, " colour"}, bad_col, 0);
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({name, " pt x*1000+y"}, obs_q[i].x * 1000 + obs_q[i].y,
                  exp_q[i].x * 1000 + exp_q[i].y);
        // start still held: done must persist with no plots
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, " done held"}, int'(bus.done), 1);
            check({name, " no plot after done"}, int'(bus.vga_plot), 0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check({name, " done drop"}, int'(bus.done), 0);
    endtask

    initial begin
        vec_t tbl[NT];
        int   cyc_of[NT];
        bit   seen[int];
        int   dx, dy, d, bad, cx, cy, r;
        bit   f;
        logic [7:0] m;
        logic [2:0] col;

        bus.start = 1'b0; bus.colour = 3'd0; bus.centre_x = '0; bus.centre_y = '0;
        bus.radius = '0; bus.fill = 1'b0; bus.octant_mask = 8'h00;

        #1;
        check("reset plot", int'(bus.vga_plot), 0);
        check("reset done", int'(bus.done), 0);
        check("reset xy", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        tbl[0]  = '{10, 10, 1, 1'b0, 8'hFF, 16, 19};
        tbl[1]  = '{5, 5, 0, 1'b0, 8'hFF, 8, 10};
        tbl[2]  = '{5, 5, 0, 1'b1, 8'hFF, 4, 6};
        tbl[3]  = '{10, 10, 1, 1'b1, 8'hFF, 20, 23};
        tbl[4]  = '{80, 60, 40, 1'b0, 8'hFF, -1, -1};
        tbl[5]  = '{0, 0, 10, 1'b0, 8'hFF, -1, -1};
        tbl[6]  = '{80, 60, 10, 1'b0, 8'hFF, -1, -1};
        tbl[7]  = '{80, 60, 20, 1'b0, 8'h01, -1, -1};
        tbl[8]  = '{80, 60, 20, 1'b0, 8'hFF, -1, -1};
        tbl[9]  = '{20, 20, 3, 1'b1, 8'hFF, -1, -1};
        tbl[10] = '{159, 119, 30, 1'b0, 8'hA5, -1, -1};
        tbl[11] = '{255, 127, 100, 1'b0, 8'hFF, -1, -1};

        for (int i = 0; i < NT; i++) begin
            run_case($sformatf("tbl%0d", i), tbl[i].cx, tbl[i].cy, tbl[i].r, tbl[i].f,
                     tbl[i].m, 3'(i + 1));
            cyc_of[i] = obs_cyc;
            if (tbl[i].exp_plots >= 0) begin
                check($sformatf("tbl%0d const plots", i), obs_q.size(), tbl[i].exp_plots);
                check($sformatf("tbl%0d const cycles", i), obs_cyc, tbl[i].exp_cycles);
            end
            seen.delete();
            foreach (obs_q[j]) seen[(obs_q[j].x - tbl[i].cx + 500) * 1000 + (obs_q[j].y - tbl[i].cy + 500)] = 1'b1;
            bad = 0;
            case (i)
                1, 2: foreach (obs_q[j]) if (obs_q[j].x != 5 || obs_q[j].y != 5) bad++;
                4: foreach (obs_q[j]) begin
                    dx = obs_q[j].x - 80; dy = obs_q[j].y - 60;
                    d  = dx * dx + dy * dy - 1600;
                    if (d > 40 || d < -40) bad++;
                    if (!seen.exists((dy + 500) * 1000 + (dx + 500))) bad++;
                    if (!seen.exists((-dx + 500) * 1000 + (dy + 500))) bad++;
                    if (!seen.exists((dx + 500) * 1000 + (-dy + 500))) bad++;
                end
                5: foreach (obs_q[j]) if (obs_q[j].x >= SW || obs_q[j].y >= SH) bad++;
                7: foreach (obs_q[j]) begin
                    dx = obs_q[j].x - 80; dy = obs_q[j].y - 60;
                    if (dx < 0 || dy < 0 || dx < dy) bad++;
                end
                9: begin
                    for (int a = -5; a <= 5; a++)
                        for (int b = -5; b <= 5; b++)
                            if (a * a + b * b <= 9 && !seen.exists((a + 500) * 1000 + (b + 500))) bad++;
                    foreach (obs_q[j]) begin
                        dx = obs_q[j].x - 20; dy = obs_q[j].y - 20;
                        if (dx * dx + dy * dy > 12) bad++;
                    end
                end
                default: bad = 0;
            endcase
            check($sformatf("tbl%0d property violations", i), bad, 0);
        end
        check("clip cycles equal unclipped", cyc_of[5], cyc_of[6]);
        check("mask cycles equal full mask", cyc_of[7], cyc_of[8]);

        // Reset mid-draw, then a clean restart
        bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.radius = 8'd40;
        bus.fill = 1'b0; bus.octant_mask = 8'hFF; bus.colour = 3'd7;
        bus.start = 1'b1;
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midreset plot", int'(bus.vga_plot), 0);
        check("midreset done", int'(bus.done), 0);
        check("midreset xy", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.vga_plot !== 1'b0) bad++;
        end
        check("plots while in reset", bad, 0);
        bus.start = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_case("restart", 10, 10, 1, 1'b0, 8'hFF, 3'd4);

        for (int t = 0; t < 25; t++) begin
            f   = ($urandom_range(0, 2) == 0);
            r   = f ? $urandom_range(0, 15) : $urandom_range(0, 150);
            cx  = $urandom_range(0, 255);
            cy  = $urandom_range(0, 127);
            m   = 8'($urandom);
            col = 3'($urandom);
            run_case($sformatf("rand%0d", t), cx, cy, r, f, m, col);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
